// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter
// Shares the register file's single write port (A3/WD3/WE3) between the ALU
// writeback (port 0) and the load-unit writeback (port 1). Each port uses a
// valid/ready handshake. Simultaneous requests are resolved round-robin. The
// write port outputs are registered, and writes to register 0 are dropped.
//
// Optional feature: define RF_WRITE_ARB_CLEAR_EN to compile in a post-reset
// CLEAR walk that zeroes every register before traffic is accepted. Without
// the macro the block resets straight into arbitration and busy is tied low.
//
// Reset is asynchronous and active-low on rst.

module rf_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_valid,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_data,
  output logic              p0_ready,
  input  logic              p1_valid,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_data,
  output logic              p1_ready,
  output logic [ADDR_W-1:0] rf_a3,
  output logic [DATA_W-1:0] rf_wd3,
  output logic              rf_we3,
  output logic              busy,
  output logic [15:0]       conflict_cnt
);

  logic              in_arb;
  logic [ADDR_W-1:0] clear_a3;

  logic              grant0;
  logic              grant1;
  logic              xfer0;
  logic              xfer1;
  logic              both_valid;

  logic              last_grant_q, last_grant_d;
  logic [ADDR_W-1:0] rf_a3_q, rf_a3_d;
  logic [DATA_W-1:0] rf_wd3_q, rf_wd3_d;
  logic              rf_we3_q, rf_we3_d;
  logic [15:0]       conflict_cnt_q, conflict_cnt_d;

`ifdef RF_WRITE_ARB_CLEAR_EN
  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_ARB   = 1'b1;

  logic [0:0]        state_q, state_d;
  logic [ADDR_W-1:0] clear_idx_q, clear_idx_d;

  // Walk the clear index once; leave CLEAR on the edge that writes the last register.
  always_comb begin
    state_d     = state_q;
    clear_idx_d = clear_idx_q;
    if (state_q == ST_CLEAR) begin
      clear_idx_d = clear_idx_q + 1'b1;
      if (clear_idx_q == {ADDR_W{1'b1}}) begin
        state_d = ST_ARB;
      end
    end
  end

  // Clear-sequence state; any reset restarts the walk from register 0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_CLEAR;
      clear_idx_q <= '0;
    end else begin
      state_q     <= state_d;
      clear_idx_q <= clear_idx_d;
    end
  end

  assign in_arb   = (state_q == ST_ARB);
  assign clear_a3 = clear_idx_q;
`else
  assign in_arb   = 1'b1;
  assign clear_a3 = '0;
`endif

  assign busy = ~in_arb;

  // Round-robin: a lone request always wins; on a tie the port that did not
  // win last time is served. last_grant_q = 1 means port 1 won last.
  assign both_valid = p0_valid & p1_valid;
  assign grant0     = p0_valid & (~p1_valid | last_grant_q);
  assign grant1     = p1_valid & (~p0_valid | ~last_grant_q);

  // Ready is gated by rst so nothing is acknowledged while reset is held,
  // even in the build that resets directly into arbitration.
  assign p0_ready = rst & in_arb & grant0;
  assign p1_ready = rst & in_arb & grant1;
  assign xfer0    = p0_valid & p0_ready;
  assign xfer1    = p1_valid & p1_ready;

  // Next write-port value: clear writes, accepted requests, or an idle cycle
  // that drops WE but keeps address/data stable.
  always_comb begin
    rf_we3_d     = 1'b0;
    rf_a3_d      = rf_a3_q;
    rf_wd3_d     = rf_wd3_q;
    last_grant_d = last_grant_q;
    if (!in_arb) begin
      rf_we3_d = 1'b1;
      rf_a3_d  = clear_a3;
      rf_wd3_d = '0;
    end else if (xfer0) begin
      rf_we3_d     = (p0_addr != '0);
      rf_a3_d      = p0_addr;
      rf_wd3_d     = p0_data;
      last_grant_d = 1'b0;
    end else if (xfer1) begin
      rf_we3_d     = (p1_addr != '0);
      rf_a3_d      = p1_addr;
      rf_wd3_d     = p1_data;
      last_grant_d = 1'b1;
    end
  end

  // Count arbitration cycles with both ports requesting, saturating at all ones.
  always_comb begin
    conflict_cnt_d = conflict_cnt_q;
    if (in_arb && both_valid && (conflict_cnt_q != 16'hFFFF)) begin
      conflict_cnt_d = conflict_cnt_q + 16'd1;
    end
  end

  // Output registers, grant history and conflict counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rf_we3_q       <= 1'b0;
      rf_a3_q        <= '0;
      rf_wd3_q       <= '0;
      last_grant_q   <= 1'b1;
      conflict_cnt_q <= '0;
    end else begin
      rf_we3_q       <= rf_we3_d;
      rf_a3_q        <= rf_a3_d;
      rf_wd3_q       <= rf_wd3_d;
      last_grant_q   <= last_grant_d;
      conflict_cnt_q <= conflict_cnt_d;
    end
  end

  assign rf_we3       = rf_we3_q;
  assign rf_a3        = rf_a3_q;
  assign rf_wd3       = rf_wd3_q;
  assign conflict_cnt = conflict_cnt_q;

endmodule
